// File: rtl/identity_seq_pkg.sv
// Shared types and constants for the identity-run stimulus sequencer.
// The stimulus bus is packed {wire0,wire1,wire2,wire3,wire4}, with wire4 in the LSBs.
package identity_seq_pkg;

    localparam int VEC_W = 83;
    localparam int Y_W   = 245;
    localparam int DEPTH = 32;
    localparam int HOLD  = 10;
    localparam int GAP_W = 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int CNT_W = ($clog2(HOLD) > GAP_W) ? $clog2(HOLD) : GAP_W;

    localparam int W0_W = 17;
    localparam int W1_W = 11;
    localparam int W2_W = 12;
    localparam int W3_W = 21;
    localparam int W4_W = 22;
    localparam int W4_LSB = 0;
    localparam int W3_LSB = W4_LSB + W4_W;
    localparam int W2_LSB = W3_LSB + W3_W;
    localparam int W1_LSB = W2_LSB + W2_W;
    localparam int W0_LSB = W1_LSB + W1_W;

    typedef enum logic [1:0] {IDLE, APPLY, GAP, FIN} state_t;

    typedef struct packed {
        logic [GAP_W-1:0] gap;
        logic [VEC_W-1:0] vec;
    } entry_t;

    function automatic logic [VEC_W-1:0] pack_wires(
        input logic [W0_W-1:0] w0,
        input logic [W1_W-1:0] w1,
        input logic [W2_W-1:0] w2,
        input logic [W3_W-1:0] w3,
        input logic [W4_W-1:0] w4
    );
        logic [VEC_W-1:0] v;
        v = '0;
        v[W0_LSB +: W0_W] = w0;
        v[W1_LSB +: W1_W] = w1;
        v[W2_LSB +: W2_W] = w2;
        v[W3_LSB +: W3_W] = w3;
        v[W4_LSB +: W4_W] = w4;
        return v;
    endfunction

endpackage

// File: rtl/identity_vec_mem.sv
// Vector table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded table survives rst_n.
module identity_vec_mem
    import identity_seq_pkg::*;
(
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  entry_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output entry_t        rdata_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/identity_vector_sequencer.sv
// Replays the vector table onto the shared stimulus bus and compares y_ref against y_dut
// once per phase. State | meaning:
//   IDLE  | stim=0; waiting for start, or one launch cycle while table[0] is fetched
//   APPLY | stim=table[idx].vec for HOLD cycles, compare on the last one
//   GAP   | stim=0 for table[idx].gap cycles, compare on the last one
//   FIN   | done pulse, busy still high, back to IDLE
module identity_vector_sequencer
    import identity_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cfg_we_i,
    input  logic [AW-1:0]    cfg_addr_i,
    input  logic [VEC_W-1:0] cfg_vec_i,
    input  logic [GAP_W-1:0] cfg_gap_i,
    input  logic [LW-1:0]    cfg_len_i,
    input  logic             start_i,
    output logic [VEC_W-1:0] stim_o,
    input  logic [Y_W-1:0]   y_ref_i,
    input  logic [Y_W-1:0]   y_dut_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mismatch_o,
    output logic [15:0]      mismatch_cnt_o,
    output logic [AW-1:0]    first_fail_o
);

    state_t           state_q;
    logic             launch_q;
    logic [AW-1:0]    idx_q;
    logic [LW-1:0]    len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [GAP_W-1:0] gap_q;
    logic [VEC_W-1:0] stim_q;
    logic             busy_q;
    logic             done_q;
    logic             mismatch_q;
    logic [15:0]      mcnt_q;
    logic [AW-1:0]    first_fail_q;

    logic [AW-1:0]    rd_idx_d;
    logic [LW-1:0]    len_d;
    logic             phase_end;
    logic             last_idx;
    logic             advance;
    logic             cmp_fail;
    logic             wr_en;
    entry_t           wr_entry;
    entry_t           rd_entry;

    assign wr_en    = cfg_we_i && !busy_q;
    assign wr_entry = '{gap: cfg_gap_i, vec: cfg_vec_i};

    identity_vec_mem u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (cfg_addr_i),
        .wdata_i (wr_entry),
        .raddr_i (rd_idx_d),
        .rdata_o (rd_entry)
    );

    // The read port looks at the index of the phase being loaded at the next edge, so the
    // next vector is ready the same cycle the current phase ends.
    always_comb begin
        phase_end = ((state_q == APPLY) || (state_q == GAP)) && (cnt_q == '0);
        last_idx  = ({1'b0, idx_q} == (len_q - LW'(1)));
        advance   = phase_end && !last_idx && ((state_q == GAP) || (gap_q == '0));
        rd_idx_d  = advance ? (idx_q + AW'(1)) : idx_q;
        len_d     = (cfg_len_i > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len_i;
        // Written as if/else so an unknown y bit lands on the failing branch.
        cmp_fail  = 1'b1;
        if (y_ref_i == y_dut_i) cmp_fail = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            launch_q     <= 1'b0;
            idx_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            stim_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mismatch_q   <= 1'b0;
            mcnt_q       <= '0;
            first_fail_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (phase_end && cmp_fail) begin
                if (mcnt_q != 16'hFFFF) mcnt_q <= mcnt_q + 16'd1;
                if (!mismatch_q) begin
                    mismatch_q   <= 1'b1;
                    first_fail_q <= idx_q;
                end
            end
            case (state_q)
                IDLE: begin
                    stim_q <= '0;
                    if (launch_q) begin
                        launch_q <= 1'b0;
                        state_q  <= APPLY;
                        cnt_q    <= CNT_W'(HOLD - 1);
                        stim_q   <= rd_entry.vec;
                        gap_q    <= rd_entry.gap;
                    end else if (start_i) begin
                        mismatch_q   <= 1'b0;
                        mcnt_q       <= '0;
                        first_fail_q <= '0;
                        idx_q        <= '0;
                        len_q        <= len_d;
                        busy_q       <= 1'b1;
                        if (len_d == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            launch_q <= 1'b1;
                        end
                    end
                end
                APPLY, GAP: begin
                    if (!phase_end) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if ((state_q == APPLY) && (gap_q != '0)) begin
                        state_q <= GAP;
                        cnt_q   <= CNT_W'(gap_q) - CNT_W'(1);
                        stim_q  <= '0;
                    end else if (last_idx) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        stim_q  <= '0;
                    end else begin
                        state_q <= APPLY;
                        idx_q   <= rd_idx_d;
                        cnt_q   <= CNT_W'(HOLD - 1);
                        stim_q  <= rd_entry.vec;
                        gap_q   <= rd_entry.gap;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    stim_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim_o         = stim_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign mismatch_o     = mismatch_q;
    assign mismatch_cnt_o = mcnt_q;
    assign first_fail_o   = first_fail_q;

endmodule

// File: tb/tb_identity_vector_sequencer.sv
// Directed and randomized replay runs checked against a cycle-list model of the table.
module tb_identity_vector_sequencer;
    import identity_seq_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             cfg_we_i;
    logic [AW-1:0]    cfg_addr_i;
    logic [VEC_W-1:0] cfg_vec_i;
    logic [GAP_W-1:0] cfg_gap_i;
    logic [LW-1:0]    cfg_len_i;
    logic             start_i;
    logic [VEC_W-1:0] stim_o;
    logic [Y_W-1:0]   y_ref_i;
    logic [Y_W-1:0]   y_dut_i;
    logic             busy_o;
    logic             done_o;
    logic             mismatch_o;
    logic [15:0]      mismatch_cnt_o;
    logic [AW-1:0]    first_fail_o;

    identity_vector_sequencer dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_vec_i      (cfg_vec_i),
        .cfg_gap_i      (cfg_gap_i),
        .cfg_len_i      (cfg_len_i),
        .start_i        (start_i),
        .stim_o         (stim_o),
        .y_ref_i        (y_ref_i),
        .y_dut_i        (y_dut_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .mismatch_o     (mismatch_o),
        .mismatch_cnt_o (mismatch_cnt_o),
        .first_fail_o   (first_fail_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_miss = 0;

    logic [VEC_W-1:0] tbl_vec [DEPTH];
    logic [GAP_W-1:0] tbl_gap [DEPTH];
    logic [Y_W-1:0]   fmask;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[VEC_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] rand_y();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
        return t[Y_W-1:0];
    endfunction

    task automatic write_entry(input int addr, input logic [VEC_W-1:0] v, input logic [GAP_W-1:0] g);
        cfg_we_i   = 1'b1;
        cfg_addr_i = AW'(addr);
        cfg_vec_i  = v;
        cfg_gap_i  = g;
        @(posedge clk_i); #1;
        cfg_we_i = 1'b0;
        tbl_vec[addr] = v;
        tbl_gap[addr] = g;
    endtask

    // Runs one replay. flip: bit p corrupts y_dut during phase p. poke_c: cycle at which a
    // stray start + table write is issued while busy. abort_c: cycle at which reset hits.
    // wr0: value written to entry 0 in the same cycle as start (0 = no write).
    task automatic run(input int len, input logic [63:0] flip, input int poke_c,
                       input int abort_c, input logic [VEC_W-1:0] wr0, input string nm);
        logic [VEC_W-1:0] exp_q [$];
        int               ph_of [$];
        int               ph_idx [$];
        int eff, np, n, d, exp_cnt, exp_first;
        logic [VEC_W-1:0] es;

        if (wr0 != '0) begin
            cfg_we_i   = 1'b1;
            cfg_addr_i = '0;
            cfg_vec_i  = wr0;
            cfg_gap_i  = tbl_gap[0];
            tbl_vec[0] = wr0;
        end
        eff = (len > DEPTH) ? DEPTH : len;
        np  = 0;
        for (int i = 0; i < eff; i++) begin
            for (int k = 0; k < HOLD; k++) begin exp_q.push_back(tbl_vec[i]); ph_of.push_back(np); end
            ph_idx.push_back(i); np++;
            if (tbl_gap[i] != 0) begin
                for (int k = 0; k < int'(tbl_gap[i]); k++) begin exp_q.push_back('0); ph_of.push_back(np); end
                ph_idx.push_back(i); np++;
            end
        end
        exp_cnt = 0; exp_first = 0;
        for (int p = np - 1; p >= 0; p--) if (flip[p]) begin exp_cnt++; exp_first = ph_idx[p]; end
        n = exp_q.size();
        d = (eff == 0) ? 0 : n + 1;

        cfg_len_i = LW'(len);
        start_i   = 1'b1;
        @(posedge clk_i); #1;
        start_i  = 1'b0;
        cfg_we_i = 1'b0;

        for (int c = 0; c <= d + 1; c++) begin
            y_ref_i = rand_y();
            y_dut_i = y_ref_i;
            if (c >= 1 && c <= n && flip[ph_of[c-1]]) y_dut_i = y_ref_i ^ fmask;
            if (c == poke_c) begin
                start_i    = 1'b1;
                cfg_we_i   = 1'b1;
                cfg_addr_i = '0;
                cfg_vec_i  = ~tbl_vec[0];
                cfg_gap_i  = tbl_gap[0] + 3'd1;
            end
            if (c == abort_c) begin
                rst_n_i = 1'b0;
                #1;
                chk($sformatf("%s abort stim", nm), 128'(stim_o), 128'(0));
                chk($sformatf("%s abort busy", nm), 128'(busy_o), 128'(0));
                chk($sformatf("%s abort mcnt", nm), 128'(mismatch_cnt_o), 128'(0));
                for (int k = 0; k < 2; k++) begin
                    @(posedge clk_i); #1;
                    chk($sformatf("%s abort done%0d", nm, k), 128'(done_o), 128'(0));
                end
                rst_n_i = 1'b1;
                y_dut_i = y_ref_i;
                @(posedge clk_i); #1;
                chk($sformatf("%s post-abort done", nm), 128'(done_o), 128'(0));
                return;
            end
            es = (c >= 1 && c <= n) ? exp_q[c-1] : '0;
            chk($sformatf("%s stim c%0d", nm, c), 128'(stim_o), 128'(es));
            chk($sformatf("%s done c%0d", nm, c), 128'(done_o), 128'(c == d));
            chk($sformatf("%s busy c%0d", nm, c), 128'(busy_o), 128'(c <= d));
            @(posedge clk_i); #1;
            start_i  = 1'b0;
            cfg_we_i = 1'b0;
        end
        y_dut_i = y_ref_i;
        chk($sformatf("%s mismatch", nm), 128'(mismatch_o), 128'(exp_cnt != 0));
        chk($sformatf("%s mcnt", nm), 128'(mismatch_cnt_o), 128'(exp_cnt));
        chk($sformatf("%s first_fail", nm), 128'(first_fail_o), 128'(exp_first));
    endtask

    initial begin
        fmask = '0;
        fmask[Y_W-1] = 1'b1;
        rst_n_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_vec_i = '0; cfg_gap_i = '0;
        cfg_len_i = '0; start_i = 1'b0; y_ref_i = '0; y_dut_i = '0;
        for (int i = 0; i < DEPTH; i++) begin tbl_vec[i] = '0; tbl_gap[i] = '0; end
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset stim", 128'(stim_o), 128'(0));
        chk("reset busy", 128'(busy_o), 128'(0));
        chk("reset done", 128'(done_o), 128'(0));
        chk("reset mismatch", 128'(mismatch_o), 128'(0));
        chk("reset mcnt", 128'(mismatch_cnt_o), 128'(0));
        chk("reset first_fail", 128'(first_fail_o), 128'(0));
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        // Table must be written after reset release; write through the whole address space.
        for (int i = 0; i < DEPTH; i++) write_entry(i, '0, '0);

        write_entry(0, 83'h1_2345_6789_ABCD_EF01, 3'd0);
        run(1, 64'd0, -1, -1, '0, "t1");

        write_entry(0, pack_wires(17'h1ABCD, 11'h3C5, 12'hA5A, 21'h12345, 22'h3F00F), 3'd2);
        write_entry(1, rand_vec() | 83'd1, 3'd0);
        write_entry(2, rand_vec() | 83'd2, 3'd3);
        run(3, 64'd0, -1, -1, '0, "t2");

        run(3, 64'h8, -1, -1, '0, "t3");
        run(3, 64'h12, -1, -1, '0, "t3b");

        run(0, 64'd0, -1, -1, '0, "t4");

        write_entry(1, tbl_vec[1], 3'd2);
        run(3, 64'd0, -1, 23, '0, "t5abort");
        run(3, 64'd0, -1, -1, '0, "t5replay");

        run(3, 64'd0, 5, -1, '0, "t6");
        run(3, 64'd0, -1, -1, '0, "t6replay");

        run(2, 64'h1, -1, -1, rand_vec() | 83'd4, "wr_start");

        for (int i = 0; i < DEPTH; i++) write_entry(i, rand_vec(), GAP_W'($urandom_range(0, 7)));
        run(40, {$urandom, $urandom}, -1, -1, '0, "clamp");
        run(1 + $urandom_range(0, DEPTH - 1), {$urandom, $urandom}, -1, -1, '0, "rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
